l2_tlb_fill_queue: RTL and testbench

L2_TLB_FILL_QUEUE -- requirements
Module: l2_tlb_fill_queue

---
 rtl/l2_tlb_fill_queue.sv | 128 ++++++++++++
 tb/tb_l2_tlb_fill_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_tlb_fill_queue.sv
// Fill queue between the PTW refill ports and the single L2 TLB write port.
// Refills are deduplicated against live entries and drained whenever the SRAM port is free.
package l2_tlb_fill_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_2M;
    logic        is_1G;
    logic [26:0] vpn;
    logic [15:0] asid;
    logic [3:0]  napot_bits;
    logic [63:0] content;
  } tlb_update_t;
endpackage

module l2_tlb_fill_queue
  import l2_tlb_fill_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ASID_WIDTH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  tlb_update_t                ptw_itlb_update_i,
  input  tlb_update_t                ptw_dtlb_update_i,
  input  logic                       l2_busy_i,
  output tlb_update_t                l2_update_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       drop_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  tlb_update_t          mem_q [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [PW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic                 empty, pop;
  logic                 itlb_dup, dtlb_dup;
  logic                 itlb_want, dtlb_want, itlb_push, dtlb_push;
  logic [CW:0]          free;
  logic [PW-1:0]        dtlb_slot;

  function automatic logic same_xlat(tlb_update_t a, tlb_update_t b);
    return (a.vpn == b.vpn) &&
           (a.asid[ASID_WIDTH-1:0] == b.asid[ASID_WIDTH-1:0]) &&
           (a.is_2M == b.is_2M) && (a.is_1G == b.is_1G);
  endfunction

  always_comb begin
    empty = (count_q == '0);
    pop   = !flush_i && !empty && !l2_busy_i;

    // The entry leaving this cycle no longer shadows an identical refill.
    itlb_dup = 1'b0;
    dtlb_dup = ptw_itlb_update_i.valid && same_xlat(ptw_itlb_update_i, ptw_dtlb_update_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !(pop && (PW'(i) == rptr_q))) begin
        if (same_xlat(mem_q[i], ptw_itlb_update_i)) itlb_dup = 1'b1;
        if (same_xlat(mem_q[i], ptw_dtlb_update_i)) dtlb_dup = 1'b1;
      end
    end

    free      = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
    itlb_want = ptw_itlb_update_i.valid && !itlb_dup && !flush_i;
    dtlb_want = ptw_dtlb_update_i.valid && !dtlb_dup && !flush_i;
    itlb_push = itlb_want && (free != '0);
    dtlb_push = dtlb_want && (free > (CW+1)'(itlb_push));
    drop_o    = (itlb_want && !itlb_push) || (dtlb_want && !dtlb_push);
    dtlb_slot = wptr_q + PW'(itlb_push);
  end

  always_comb begin
    vld_d   = vld_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      vld_d   = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      // Pop before push: when full, the freed slot is the one being written.
      if (pop) begin
        vld_d[rptr_q] = 1'b0;
        rptr_d        = rptr_q + PW'(1);
      end
      if (itlb_push) vld_d[wptr_q]    = 1'b1;
      if (dtlb_push) vld_d[dtlb_slot] = 1'b1;
      wptr_d  = wptr_q + PW'(itlb_push) + PW'(dtlb_push);
      count_d = count_q + CW'(itlb_push) + CW'(dtlb_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by vld_q and count_q.
  always_ff @(posedge clk_i) begin
    if (itlb_push) mem_q[wptr_q]    <= ptw_itlb_update_i;
    if (dtlb_push) mem_q[dtlb_slot] <= ptw_dtlb_update_i;
  end

  always_comb begin
    l2_update_o = '0;
    if (!empty) begin
      l2_update_o       = mem_q[rptr_q];
      l2_update_o.valid = 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_l2_tlb_fill_queue.sv
// Directed bench for l2_tlb_fill_queue: expected entries are queued at issue and
// checked by an independent monitor whenever the head is written to the L2 TLB.
module tb_l2_tlb_fill_queue;
  import l2_tlb_fill_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        l2_busy_i = 1'b0;
  tlb_update_t itlb = '0, dtlb = '0, l2_update_o;
  logic [2:0]  count_o;
  logic        drop_o;

  int checks = 0;
  int errors = 0;
  tlb_update_t exp_q[$];
  tlb_update_t none = '0;

  logic [2:0] s_cnt;
  logic       s_drop, s_vld;

  l2_tlb_fill_queue #(.DEPTH(DEPTH), .ASID_WIDTH(1)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .ptw_itlb_update_i (itlb),
    .ptw_dtlb_update_i (dtlb),
    .l2_busy_i         (l2_busy_i),
    .l2_update_o       (l2_update_o),
    .count_o           (count_o),
    .drop_o            (drop_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic tlb_update_t mk(logic [26:0] vpn, logic [15:0] asid, logic [63:0] content);
    tlb_update_t e;
    e            = '0;
    e.valid      = 1'b1;
    e.vpn        = vpn;
    e.asid       = asid;
    e.napot_bits = vpn[3:0];
    e.is_2M      = vpn[4];
    e.content    = content;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle; count/drop/valid are sampled mid-cycle before the edge.
  task automatic step(input tlb_update_t i, input tlb_update_t d, input logic busy, input logic fl);
    itlb      = i;
    dtlb      = d;
    l2_busy_i = busy;
    flush_i   = fl;
    @(negedge clk_i);
    s_cnt  = count_o;
    s_drop = drop_o;
    s_vld  = l2_update_o.valid;
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && l2_update_o.valid && !l2_busy_i && !flush_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual=%h required=none", l2_update_o);
      end else begin
        tlb_update_t e;
        e = exp_q.pop_front();
        if (l2_update_o !== e) begin
          errors++;
          $display("FAIL out_entry actual=%h required=%h", l2_update_o, e);
        end
      end
    end
  end

  initial begin
    tlb_update_t a, b, d, d2, e, f, x;
    itlb = mk(27'h1, 16'h0, 64'h1);
    #12;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_drop", 64'(drop_o), 64'd0);
    chk("rst_out", 64'(l2_update_o == '0), 64'd1);
    itlb = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // single refill, no bypass, popped next cycle
    a = mk(27'h12345, 16'h0, 64'hAAAA_0001);
    exp_q.push_back(a);
    step(a, none, 1'b0, 1'b0);
    chk("t1_nobypass", 64'(s_vld), 64'd0);
    chk("t1_cnt0", 64'(s_cnt), 64'd0);
    step(none, none, 1'b0, 1'b0);
    chk("t1_cnt1", 64'(s_cnt), 64'd1);
    chk("t1_vld", 64'(s_vld), 64'd1);
    step(none, none, 1'b0, 1'b0);
    chk("t1_cnt_end", 64'(s_cnt), 64'd0);

    // both ports while busy, ITLB first
    a = mk(27'h0A0A, 16'h0, 64'hA);
    b = mk(27'h0B0B, 16'h0, 64'hB);
    exp_q.push_back(a);
    exp_q.push_back(b);
    step(a, b, 1'b1, 1'b0);
    step(none, none, 1'b1, 1'b0);
    chk("t2_cnt2", 64'(s_cnt), 64'd2);
    step(none, none, 1'b0, 1'b0);
    step(none, none, 1'b0, 1'b0);
    chk("t2_cnt1", 64'(s_cnt), 64'd1);
    step(none, none, 1'b0, 1'b0);
    chk("t2_cnt_end", 64'(s_cnt), 64'd0);

    // overflow: one slot with two inputs keeps ITLB; then full
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(27'(32'h100 + k), 16'h0, 64'(k)));
    step(mk(27'h101, 16'h0, 64'd1), mk(27'h102, 16'h0, 64'd2), 1'b1, 1'b0);
    chk("t3_drop_a", 64'(s_drop), 64'd0);
    step(mk(27'h103, 16'h0, 64'd3), none, 1'b1, 1'b0);
    chk("t3_cnt2", 64'(s_cnt), 64'd2);
    step(mk(27'h104, 16'h0, 64'd4), mk(27'h105, 16'h0, 64'd5), 1'b1, 1'b0);
    chk("t3_cnt3", 64'(s_cnt), 64'd3);
    chk("t3_drop_dtlb", 64'(s_drop), 64'd1);
    step(mk(27'h106, 16'h0, 64'd6), none, 1'b1, 1'b0);
    chk("t3_cnt_full", 64'(s_cnt), 64'd4);
    chk("t3_drop_full", 64'(s_drop), 64'd1);
    step(none, none, 1'b1, 1'b0);
    chk("t3_drop_clear", 64'(s_drop), 64'd0);
    chk("t3_cnt_hold", 64'(s_cnt), 64'd4);
    for (int k = 0; k < 4; k++) step(none, none, 1'b0, 1'b0);
    step(none, none, 1'b0, 1'b0);
    chk("t3_cnt_end", 64'(s_cnt), 64'd0);

    // deduplication, ASID compared only on its low bit
    d  = mk(27'h777, 16'h0, 64'hD1);
    d2 = mk(27'h777, 16'h0, 64'hD2);
    e  = mk(27'h777, 16'h1, 64'hE1);
    f  = mk(27'h777, 16'h2, 64'hF1);
    exp_q.push_back(d);
    exp_q.push_back(e);
    step(d, d2, 1'b1, 1'b0);
    chk("t4_drop_a", 64'(s_drop), 64'd0);
    step(d, none, 1'b1, 1'b0);
    chk("t4_cnt1", 64'(s_cnt), 64'd1);
    chk("t4_drop_b", 64'(s_drop), 64'd0);
    step(e, none, 1'b1, 1'b0);
    chk("t4_cnt1b", 64'(s_cnt), 64'd1);
    step(f, none, 1'b1, 1'b0);
    chk("t4_cnt2", 64'(s_cnt), 64'd2);
    chk("t4_drop_c", 64'(s_drop), 64'd0);
    step(none, none, 1'b1, 1'b0);
    chk("t4_cnt_final", 64'(s_cnt), 64'd2);
    step(none, none, 1'b0, 1'b0);
    step(none, none, 1'b0, 1'b0);
    step(none, none, 1'b0, 1'b0);
    chk("t4_cnt_end", 64'(s_cnt), 64'd0);

    // flush with a full load of inputs
    step(mk(27'h201, 16'h0, 64'h1), mk(27'h202, 16'h0, 64'h2), 1'b1, 1'b0);
    step(mk(27'h203, 16'h0, 64'h3), none, 1'b1, 1'b0);
    exp_q.delete();
    step(mk(27'h204, 16'h0, 64'h4), mk(27'h205, 16'h0, 64'h5), 1'b1, 1'b1);
    chk("t5_cnt3", 64'(s_cnt), 64'd3);
    chk("t5_drop", 64'(s_drop), 64'd0);
    step(none, none, 1'b0, 1'b0);
    chk("t5_cnt0", 64'(s_cnt), 64'd0);
    chk("t5_vld0", 64'(s_vld), 64'd0);
    step(none, none, 1'b1, 1'b0);
    chk("t5_idle_cnt", 64'(s_cnt), 64'd0);

    // full queue with simultaneous pop and push, pointer wrap
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(27'(32'h300 + k), 16'h0, 64'(k)));
    step(mk(27'h300, 16'h0, 64'd0), mk(27'h301, 16'h0, 64'd1), 1'b1, 1'b0);
    step(mk(27'h302, 16'h0, 64'd2), mk(27'h303, 16'h0, 64'd3), 1'b1, 1'b0);
    for (int k = 0; k < 2 * DEPTH; k++) begin
      exp_q.push_back(mk(27'(32'h400 + k), 16'h1, 64'(k + 100)));
      step(mk(27'(32'h400 + k), 16'h1, 64'(k + 100)), none, 1'b0, 1'b0);
      chk($sformatf("t6_cnt_%0d", k), 64'(s_cnt), 64'd4);
      chk($sformatf("t6_drop_%0d", k), 64'(s_drop), 64'd0);
    end
    for (int k = 0; k < 4; k++) step(none, none, 1'b0, 1'b0);
    step(none, none, 1'b0, 1'b0);
    chk("t6_cnt_end", 64'(s_cnt), 64'd0);

    // refill matching only the entry popped this cycle is kept
    x = mk(27'h5A5A, 16'h0, 64'h55);
    exp_q.push_back(x);
    exp_q.push_back(x);
    step(x, none, 1'b1, 1'b0);
    step(x, none, 1'b0, 1'b0);
    chk("t7_cnt1", 64'(s_cnt), 64'd1);
    step(none, none, 1'b0, 1'b0);
    chk("t7_cnt_again", 64'(s_cnt), 64'd1);
    step(none, none, 1'b0, 1'b0);
    chk("t7_cnt_end", 64'(s_cnt), 64'd0);

    // asynchronous reset mid-operation
    step(mk(27'h601, 16'h0, 64'h1), mk(27'h602, 16'h0, 64'h2), 1'b1, 1'b0);
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    chk("t8_cnt", 64'(count_o), 64'd0);
    chk("t8_out", 64'(l2_update_o == '0), 64'd1);
    chk("t8_drop", 64'(drop_o), 64'd0);
    itlb = '0;
    dtlb = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step(none, none, 1'b0, 1'b0);
    chk("t8_cnt_after", 64'(s_cnt), 64'd0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
